// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: registered one-hot grant, address/data-phase
// owner pipeline, and grant hold across fixed bursts, INCR bursts and locks.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned MASTER_W       = 2,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRST,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_W-1:0]    HMASTER,
  output logic [MASTER_W-1:0]    HMASTER_DATA,
  output logic                   HMASTLOCK
);

  typedef enum logic [2:0] {
    ST_PARK,
    ST_SINGLE,
    ST_BURST,
    ST_INCR,
    ST_LOCK
  } state_t;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_t;

  localparam logic [MASTER_W-1:0]    DEF_IDX   = MASTER_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  // Registered state
  state_t                   r_state;
  logic [3:0]               r_beats;
  logic                     r_lock_tail;
  logic [MASTER_W-1:0]      r_ptr;
  logic [MASTER_W-1:0]      r_gidx;
  logic [NUM_MASTERS-1:0]   r_grant;
  logic [MASTER_W-1:0]      r_hmaster;
  logic [MASTER_W-1:0]      r_hmaster_data;
  logic                     r_hmastlock;

  // Combinational decode
  htrans_t                  w_trans;
  logic                     w_own_req;
  logic                     w_own_lock;
  logic [3:0]               w_burst_last;
  logic                     w_new_hold;
  logic                     w_rearb_gen;
  state_t                   w_gen_state;
  logic [3:0]               w_gen_beats;
  state_t                   w_state_nx;
  logic [3:0]               w_beats_nx;
  logic                     w_tail_nx;
  logic                     w_rearb;
  logic                     w_any;
  logic [MASTER_W-1:0]      w_win;
  logic [MASTER_W-1:0]      w_idx;
  logic [MASTER_W-1:0]      w_grant_idx;
  logic [NUM_MASTERS-1:0]   w_grant_oh;

  assign w_trans    = htrans_t'(HTRANS);
  assign w_own_req  = HBUSREQ[r_hmaster];
  assign w_own_lock = HLOCK[r_hmaster];

  // Remaining beats after the NONSEQ of a fixed-length burst
  always_comb begin
    w_burst_last = '0;
    unique case (HBURST)
      3'd2, 3'd3: w_burst_last = 4'd3;
      3'd4, 3'd5: w_burst_last = 4'd7;
      3'd6, 3'd7: w_burst_last = 4'd15;
      default:    w_burst_last = '0;
    endcase
  end

  // A NONSEQ starting a locked, fixed-length or still-requested INCR burst
  // must keep the grant; the decision is taken on that first beat rather
  // than on the state it leaves, so a burst is never split after one beat.
  assign w_new_hold  = r_hmastlock || (HBURST >= 3'd2) ||
                       ((HBURST == 3'd1) && w_own_req);
  assign w_rearb_gen = (w_trans == TR_NONSEQ) ? !w_new_hold : 1'b1;

  // State implied by the beat being accepted, independent of current state
  always_comb begin
    w_gen_state = r_state;
    w_gen_beats = r_beats;
    unique case (w_trans)
      TR_NONSEQ: begin
        w_gen_beats = '0;
        if (r_hmastlock)            w_gen_state = ST_LOCK;
        else if (HBURST == 3'd0)    w_gen_state = ST_SINGLE;
        else if (HBURST == 3'd1)    w_gen_state = ST_INCR;
        else begin
          w_gen_state = ST_BURST;
          w_gen_beats = w_burst_last;
        end
      end
      TR_IDLE: begin
        w_gen_state = ST_PARK;
        w_gen_beats = '0;
      end
      default: begin
        w_gen_state = r_state;
        w_gen_beats = r_beats;
      end
    endcase
  end

  // Next-state and rearbitration-permission logic
  always_comb begin
    w_state_nx = r_state;
    w_beats_nx = r_beats;
    w_tail_nx  = 1'b0;
    w_rearb    = 1'b0;
    unique case (r_state)
      ST_PARK, ST_SINGLE: begin
        w_rearb    = w_rearb_gen;
        w_state_nx = w_gen_state;
        w_beats_nx = w_gen_beats;
      end
      ST_BURST: begin
        unique case (w_trans)
          TR_SEQ: begin
            if (r_beats <= 4'd1) begin
              w_rearb    = 1'b1;
              w_state_nx = ST_PARK;
              w_beats_nx = '0;
            end else begin
              w_beats_nx = r_beats - 4'd1;
            end
          end
          TR_BUSY: begin
            w_rearb = 1'b0;
          end
          default: begin
            // IDLE or NONSEQ before the count runs out ends the burst early
            w_rearb    = w_rearb_gen;
            w_state_nx = w_gen_state;
            w_beats_nx = w_gen_beats;
          end
        endcase
      end
      ST_INCR: begin
        w_rearb    = (w_trans == TR_NONSEQ) ? w_rearb_gen : !w_own_req;
        w_state_nx = w_gen_state;
        w_beats_nx = w_gen_beats;
      end
      ST_LOCK: begin
        if (w_own_lock || !r_lock_tail) begin
          // Hold while locked, plus one transfer after the lock is released
          w_rearb    = 1'b0;
          w_tail_nx  = !w_own_lock;
          w_state_nx = ST_LOCK;
        end else begin
          w_rearb    = 1'b1;
          w_state_nx = w_gen_state;
          w_beats_nx = w_gen_beats;
        end
      end
      default: begin
        w_state_nx = ST_PARK;
        w_beats_nx = '0;
      end
    endcase
  end

  // Round-robin search starting one past the last granted master
  always_comb begin
    w_any = 1'b0;
    w_win = DEF_IDX;
    w_idx = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = MASTER_W'((32'(r_ptr) + i) % NUM_MASTERS);
      if (!w_any && HBUSREQ[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_grant_idx = w_any ? w_win : DEF_IDX;
  assign w_grant_oh  = NUM_MASTERS'(1) << w_grant_idx;

  // FSM state register, advanced only on completed transfers
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_state     <= ST_PARK;
      r_beats     <= '0;
      r_lock_tail <= 1'b0;
    end else if (HREADY) begin
      r_state     <= w_state_nx;
      r_beats     <= w_beats_nx;
      r_lock_tail <= w_tail_nx;
    end
  end

  // Grant and round-robin pointer; parking leaves the pointer in place
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_grant <= DEF_GRANT;
      r_gidx  <= DEF_IDX;
      r_ptr   <= DEF_IDX;
    end else if (HREADY && w_rearb) begin
      r_grant <= w_grant_oh;
      r_gidx  <= w_grant_idx;
      if (w_any) r_ptr <= w_win;
    end
  end

  // Ownership pipeline: grant -> address phase -> data phase
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_hmaster      <= DEF_IDX;
      r_hmaster_data <= DEF_IDX;
      r_hmastlock    <= 1'b0;
    end else if (HREADY) begin
      r_hmaster_data <= r_hmaster;
      r_hmaster      <= r_gidx;
      r_hmastlock    <= HLOCK[r_gidx];
    end
  end

  assign HGRANT       = r_grant;
  assign HMASTER      = r_hmaster;
  assign HMASTER_DATA = r_hmaster_data;
  assign HMASTLOCK    = r_hmastlock;

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter for up to NUM_MASTERS masters sharing one AHB address/data path into the slave fabric.
- Grants the bus (HGRANT) and reports the address-phase owner (HMASTER) and data-phase owner (HMASTER_DATA) for the address/write-data muxes.
- Holds grant across fixed-length bursts, undefined-length INCR bursts and locked sequences.
- Parks on DEFAULT_MASTER when idle.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- MASTER_W, 2, width of master index (clog2(NUM_MASTERS))
- DEFAULT_MASTER, 0, master parked on when no requests

Ports:
- HCLK  in  1  bus clock
- HRST  in  1  reset, synchronous, active-high
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request
- HTRANS  in  2  muxed HTRANS of current address owner (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
- HBURST  in  3  muxed HBURST of current address owner
- HREADY  in  1  bus-wide transfer-complete
- HGRANT  out  NUM_MASTERS  one-hot grant, registered
- HMASTER  out  MASTER_W  address-phase owner index, registered
- HMASTER_DATA  out  MASTER_W  data-phase owner index, registered
- HMASTLOCK  out  1  current address phase is locked

Behaviour:
- Reset (HRST=1 at posedge):
  - HGRANT = one-hot DEFAULT_MASTER
  - HMASTER = HMASTER_DATA = DEFAULT_MASTER
  - HMASTLOCK = 0
  - state = PARK, beat counter = 0, round-robin pointer = DEFAULT_MASTER
  - Reset mid-burst or mid-lock aborts immediately to these values.
- All outputs update only on posedges where HREADY=1. With HREADY=0, every register holds.
- Ownership pipeline, on each HREADY=1 edge:
  - HMASTER_DATA <= HMASTER
  - HMASTER <= index(HGRANT)
  - HMASTLOCK <= HLOCK[index(HGRANT)]
  - A new grant therefore owns the address phase one HREADY cycle after HGRANT asserts, and the data phase one further HREADY cycle later.
- Arbitration:
  - Search starts at (last granted + 1) mod NUM_MASTERS, wrapping; the first index with HBUSREQ=1 wins.
  - No request: grant DEFAULT_MASTER (PARK).
  - If only the current owner requests, it keeps the grant.
- Rearbitration is allowed (rearb_ok) when:
  - state PARK or SINGLE;
  - or BURST with beats_left <= 1 and HTRANS is NONSEQ/SEQ (the last beat address is being accepted);
  - or INCR with HBUSREQ[owner]=0;
  - never in LOCK while HLOCK[owner]=1.
- HGRANT <= arbitration result on HREADY=1 edges where rearb_ok; otherwise HGRANT holds.
- States (evaluated on HREADY=1 edges for the current address owner):
  - PARK: no real owner, HTRANS expected IDLE. On NONSEQ go to SINGLE, BURST or INCR per HBURST, or to LOCK if HMASTLOCK.
  - SINGLE: HBURST=0, single transfer. Next NONSEQ re-evaluates; IDLE returns to PARK.
  - BURST: HBURST in 2..7. On the NONSEQ beat, beats_left = 4/8/16 (WRAP4/INCR4 = 4, WRAP8/INCR8 = 8, WRAP16/INCR16 = 16), minus 1.
    - Each SEQ with HREADY decrements beats_left; BUSY does not decrement.
    - Done when beats_left reaches 0.
    - Early termination (IDLE or NONSEQ before beats_left=0): treat as done and re-evaluate.
  - INCR: HBURST=1. Held while HBUSREQ[owner]=1; once it drops, rearbitrate at the next HREADY edge.
  - LOCK: entered when HMASTLOCK=1 on NONSEQ. Grant held while HLOCK[owner]=1. After HLOCK drops, the grant is held for one further HREADY transfer, then rearbitrated.
- Round-robin pointer updates only when HGRANT changes to a requesting master. Parking does not move it.
- Simultaneous events:
  - Owner drops HBUSREQ while other masters request in the same cycle: the next master in round-robin order wins.
  - HBUSREQ and HLOCK both asserted by a new master: lock applies from its first NONSEQ.
- HGRANT is always exactly one-hot, never zero.

Test Plan:
- Reset, no requests: HRST=1 for 2 cycles, then HBUSREQ=0 -> HGRANT=4'b0001, HMASTER=0, HMASTER_DATA=0, HMASTLOCK=0, stable for 10 cycles.
- Round robin: HBUSREQ=4'b1111, SINGLE NONSEQ transfers, HREADY=1 -> HGRANT sequence 0001→0010→0100→1000→0001. HMASTER lags one cycle and HMASTER_DATA lags two.
- INCR4 held: master 2 granted, HBURST=3, NONSEQ + 3 SEQ, master 1 requesting, one BUSY mid-burst -> HGRANT stays 0100 until the 4th beat address is accepted, then becomes 0010. BUSY does not count as a beat.
- Wait states: during a burst, HREADY=0 for 3 cycles -> HGRANT, HMASTER and HMASTER_DATA frozen, beat counter unchanged.
- Locked: master 3 HLOCK=1 plus HBUSREQ, master 0 requesting -> HMASTLOCK=1 with HMASTER=3. Grant is held for 5 transfers while HLOCK=1, then 1 further transfer after HLOCK drops, then moves to master 0.
- Reset mid-burst: HRST=1 during beat 2 of INCR8 -> next edge HGRANT=0001, HMASTER=0, state PARK, beat counter 0.
